chebyshev_sequencer: RTL

//  Control FSM for the chebyshev_computation datapath. Holds a coefficient RAM and the polynomial order N.
//  For each accepted sample x it streams coefficients c[N]..c[0] (Clenshaw order) into the datapath.
//  It then waits the datapath latency, captures the result and presents it on a valid/ready output.

---
 rtl/chebyshev_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/chebyshev_sequencer.sv
// Control FSM for the Chebyshev datapath. It holds the coefficient RAM and the
// order N, and for each accepted sample streams c[N]..c[0] (Clenshaw order).
// It then waits for the datapath result and presents it on a valid/ready output.
//
// Ports:
//   clock, reset                   rising-edge clock, synchronous active-high reset
//   cfg_we/cfg_addr/cfg_coeff      coefficient RAM write, honoured only in IDLE
//   cfg_order_we/cfg_order         order N write, saturated to ORDER_MAX, only in IDLE
//   cfg_ready                      config writes accepted this cycle
//   in_valid/in_ready/in_x         sample handshake
//   dp_start/dp_coeff_valid        datapath control (recurrence clear / coefficient strobe)
//   dp_data/dp_coeff               latched sample and current coefficient
//   dp_result                      datapath result, captured once per evaluation
//   out_valid/out_ready/out_y      result handshake
//   busy                           an evaluation is in progress
//
// Every output is registered. Only one evaluation is in flight at a time.
module chebyshev_sequencer #(
  parameter int WL         = 16,
  parameter int CL         = 16,
  parameter int ORDER_MAX  = 7,
  parameter int DP_LATENCY = 2,
  localparam int AW        = (ORDER_MAX > 0) ? $clog2(ORDER_MAX + 1) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [CL-1:0] cfg_coeff,
  input  logic          cfg_order_we,
  input  logic [AW-1:0] cfg_order,
  output logic          cfg_ready,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WL-1:0] in_x,
  output logic          dp_start,
  output logic          dp_coeff_valid,
  output logic [WL-1:0] dp_data,
  output logic [CL-1:0] dp_coeff,
  input  logic [WL-1:0] dp_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WL-1:0] out_y,
  output logic          busy
);

  // Counter wide enough to hold DP_LATENCY itself.
  localparam int CW = (DP_LATENCY > 0) ? $clog2(DP_LATENCY + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [CL-1:0] coeff_ram [0:ORDER_MAX];
  logic [AW-1:0] order;
  logic [AW-1:0] idx;
  logic [CW-1:0] drain_cnt;

  logic [AW-1:0] idx_next;
  logic [AW-1:0] order_sat;
  logic          addr_ok;

  always_comb begin
    idx_next  = idx - AW'(1);
    order_sat = (int'(cfg_order) > ORDER_MAX) ? AW'(ORDER_MAX) : cfg_order;
    addr_ok   = (int'(cfg_addr) <= ORDER_MAX);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      for (int i = 0; i <= ORDER_MAX; i++) begin
        coeff_ram[i] <= '0;
      end
      order          <= '0;
      idx            <= '0;
      drain_cnt      <= '0;
      cfg_ready      <= 1'b1;
      in_ready       <= 1'b1;
      dp_start       <= 1'b0;
      dp_coeff_valid <= 1'b0;
      dp_data        <= '0;
      dp_coeff       <= '0;
      out_valid      <= 1'b0;
      out_y          <= '0;
      busy           <= 1'b0;
    end else begin
      // dp_start is a single-cycle pulse; only the accepting edge raises it.
      dp_start <= 1'b0;

      case (state)
        IDLE: begin
          if (cfg_we && addr_ok) begin
            coeff_ram[cfg_addr] <= cfg_coeff;
          end
          if (cfg_order_we) begin
            order <= order_sat;
          end
          // A sample accepted alongside an order write uses the old order:
          // 'order' below still reads its pre-edge value.
          if (in_valid) begin
            dp_data        <= in_x;
            idx            <= order;
            dp_coeff       <= coeff_ram[order];
            dp_coeff_valid <= 1'b1;
            dp_start       <= 1'b1;
            in_ready       <= 1'b0;
            cfg_ready      <= 1'b0;
            busy           <= 1'b1;
            state          <= ISSUE;
          end
        end

        ISSUE: begin
          if (idx == '0) begin
            dp_coeff_valid <= 1'b0;
            dp_coeff       <= '0;
            // The datapath takes the last coefficient on this edge; its result
            // is valid DP_LATENCY edges later and is sampled on the edge after
            // that, so DRAIN lasts DP_LATENCY+1 cycles.
            drain_cnt      <= CW'(DP_LATENCY);
            state          <= DRAIN;
          end else begin
            idx      <= idx_next;
            dp_coeff <= coeff_ram[idx_next];
          end
        end

        DRAIN: begin
          if (drain_cnt == '0) begin
            out_y     <= dp_result;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            drain_cnt <= drain_cnt - CW'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
